// File: rtl/onchip_mem_pkg.sv
// Shared constants and FSM state type for the on-chip memory read master.
package onchip_mem_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 12;
    localparam int unsigned DATA_W_DEFAULT = 32;
    localparam int unsigned MEM_WORDS      = 3072;
    localparam logic [3:0]  BYTEEN_ALL     = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

endpackage

// File: rtl/stream_fifo.sv
// Synchronous FIFO with registered storage and a show-ahead head word.
module stream_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

endmodule

// File: rtl/onchip_mem_read_master.sv
// Avalon-MM read master: fetches a block of consecutive words and streams them out
// through a credit-protected FIFO.
module onchip_mem_read_master
    import onchip_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEFAULT,
    parameter int unsigned DATA_W     = DATA_W_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic [3:0]        avm_byteenable,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    input  logic              src_ready
);

    localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [CNT_W-1:0]  issue_left;
    logic [CNT_W-1:0]  recv_left;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_empty;
    logic              fifo_full;

    logic              accept;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  issue_next;
    logic [CNT_W-1:0]  recv_next;
    logic [FCNT_W-1:0] fifo_next;
    logic [CNT_W:0]    in_use_next;
    logic              credit_next;

    assign avm_byteenable = BYTEEN_ALL;
    assign src_valid      = ~fifo_empty;

    assign accept = avm_read & ~avm_waitrequest;
    // The full term never fires under the credit rule; it only keeps the FIFO safe.
    assign push   = avm_readdatavalid & (state != ST_IDLE) & ~fifo_full;
    assign pop    = src_valid & src_ready;

    assign issue_next = issue_left - CNT_W'(accept);
    assign recv_next  = recv_left - CNT_W'(push);
    assign fifo_next  = fifo_count + FCNT_W'(push) - FCNT_W'(pop);

    // Words in flight (recv_left - issue_left) plus words parked in the FIFO after this edge.
    assign in_use_next = {1'b0, recv_next - issue_next} + (CNT_W+1)'(fifo_next);
    assign credit_next = in_use_next < (CNT_W+1)'(FIFO_DEPTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            issue_left  <= '0;
            recv_left   <= '0;
        end else begin
            done       <= 1'b0;
            issue_left <= issue_next;
            recv_left  <= recv_next;
            if (accept) begin
                avm_address <= avm_address + ADDR_W'(1);
            end
            unique case (state)
                ST_IDLE: begin
                    avm_read <= 1'b0;
                    if (start) begin
                        if (word_count != '0) begin
                            state       <= ST_READ;
                            busy        <= 1'b1;
                            avm_read    <= 1'b1;
                            avm_address <= base_addr;
                            issue_left  <= word_count;
                            recv_left   <= word_count;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    // Holding a stalled request is safe: credit can only grow without acceptance.
                    avm_read <= (issue_next != '0) && credit_next;
                    if (issue_next == '0) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    avm_read <= 1'b0;
                    if (recv_next == '0 && fifo_next == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    busy     <= 1'b0;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

    stream_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (avm_readdata),
        .pop       (pop),
        .head_data (src_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule

// File: tb/tb_onchip_mem_read_master.sv
// Bench for onchip_mem_read_master: in-order Avalon slave model returning data = address.
module tb_onchip_mem_read_master;

    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic        busy;
    logic        done;
    logic [11:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;

    always #5 clk = ~clk;

    onchip_mem_read_master #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (13)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_byteenable    (avm_byteenable),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_ready         (src_ready)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        rsp_q [$];
    logic [11:0] acc_log [$];
    logic [31:0] out_log [$];
    int          kcyc = 0;
    int          last_due = 0;
    int          done_cnt, acc_cnt, deliv_cnt, max_out;
    bit          read_seen;

    int          lat_min = 1;
    int          lat_max = 1;
    bit          ready_rand = 0;
    bit          ready_on = 1;
    logic [11:0] stall_addr = '0;
    int          stall_len = 0;
    int          stall_left = 0;
    bit          stall_armed = 0;

    typedef struct {
        logic [11:0] base;
        int          cnt;
        int          lmax;
        bit          rnd;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    typedef struct {
        logic        rd;
        logic [11:0] addr;
        logic        sv;
        logic [31:0] data;
        logic        dn;
        logic        bz;
    } step_t;

    vec_t  vecs [5];
    step_t steps [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs at a negedge: observe outputs, then drive slave and sink inputs for the next posedge.
    task automatic agent_eval();
        rsp_t r;
        int   lat;
        kcyc++;
        if (done) done_cnt++;
        if (avm_read) read_seen = 1;
        src_ready = ready_rand ? ($urandom_range(3, 0) != 0) : ready_on;

        avm_readdatavalid = 1'b0;
        avm_readdata      = 32'hDEAD_BEEF;
        if (rsp_q.size() > 0 && rsp_q[0].due <= kcyc) begin
            r = rsp_q.pop_front();
            avm_readdatavalid = 1'b1;
            avm_readdata      = r.data;
            deliv_cnt++;
        end

        avm_waitrequest = 1'b0;
        if (stall_left > 0) begin
            avm_waitrequest = 1'b1;
            stall_left--;
            check("stall_read_held", 32'(avm_read), 32'd1);
            check("stall_addr_held", 32'(avm_address), 32'(stall_addr));
        end else if (stall_armed && avm_read && avm_address == stall_addr) begin
            stall_armed     = 0;
            avm_waitrequest = 1'b1;
            stall_left      = stall_len - 1;
        end

        if (avm_read && !avm_waitrequest) begin
            acc_log.push_back(avm_address);
            acc_cnt++;
            lat    = int'($urandom_range(lat_max, lat_min));
            r.data = 32'(avm_address);
            r.due  = kcyc + lat;
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            rsp_q.push_back(r);
        end
        if (acc_cnt - deliv_cnt > max_out) max_out = acc_cnt - deliv_cnt;

        if (src_valid && src_ready) out_log.push_back(src_data);
    endtask

    task automatic cycle();
        agent_eval();
        @(negedge clk);
    endtask

    task automatic clear_logs();
        acc_log.delete();
        out_log.delete();
        done_cnt  = 0;
        acc_cnt   = 0;
        deliv_cnt = 0;
        max_out   = 0;
        read_seen = 0;
    endtask

    task automatic pulse_start(input logic [11:0] b, input int n);
        base_addr  = b;
        word_count = 13'(n);
        start      = 1'b1;
        cycle();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) cycle();
        for (int i = 0; i < 4; i++) cycle();
    endtask

    // Compares both the accepted address log and the stream against base, base+1, ...
    task automatic verify_seq(input string name, input logic [11:0] b, input int n);
        int          errs = 0;
        logic [11:0] a;
        for (int i = 0; i < out_log.size() && i < n; i++) begin
            a = b + 12'(i);
            if (out_log[i] !== 32'(a)) errs++;
        end
        for (int i = 0; i < acc_log.size() && i < n; i++) begin
            a = b + 12'(i);
            if (acc_log[i] !== a) errs++;
        end
        check({name, "_words"}, 32'(out_log.size()), 32'(n));
        check({name, "_reads"}, 32'(acc_log.size()), 32'(n));
        check({name, "_order"}, 32'(errs), 32'd0);
        check({name, "_done_once"}, 32'(done_cnt), 32'd1);
        check({name, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n_at_reset;
        int done_at_reset;

        vecs[0] = '{base: 12'h010, cnt: 4,   lmax: 1, rnd: 0, exp_first: 32'h010, exp_last: 32'h013};
        vecs[1] = '{base: 12'hFFE, cnt: 4,   lmax: 1, rnd: 0, exp_first: 32'hFFE, exp_last: 32'h001};
        vecs[2] = '{base: 12'hBFF, cnt: 3,   lmax: 2, rnd: 0, exp_first: 32'hBFF, exp_last: 32'hC01};
        vecs[3] = '{base: 12'h200, cnt: 100, lmax: 4, rnd: 1, exp_first: 32'h200, exp_last: 32'h263};
        vecs[4] = '{base: 12'h7F0, cnt: 16,  lmax: 3, rnd: 1, exp_first: 32'h7F0, exp_last: 32'h7FF};

        // Cycle-by-cycle view of a 4-word read from 0x010 with a 1-cycle slave.
        steps[0] = '{rd: 1, addr: 12'h010, sv: 0, data: 32'h0,   dn: 0, bz: 1};
        steps[1] = '{rd: 1, addr: 12'h011, sv: 0, data: 32'h0,   dn: 0, bz: 1};
        steps[2] = '{rd: 1, addr: 12'h012, sv: 1, data: 32'h010, dn: 0, bz: 1};
        steps[3] = '{rd: 1, addr: 12'h013, sv: 1, data: 32'h011, dn: 0, bz: 1};
        steps[4] = '{rd: 0, addr: 12'h000, sv: 1, data: 32'h012, dn: 0, bz: 1};
        steps[5] = '{rd: 0, addr: 12'h000, sv: 1, data: 32'h013, dn: 0, bz: 1};
        steps[6] = '{rd: 0, addr: 12'h000, sv: 0, data: 32'h0,   dn: 1, bz: 0};
        steps[7] = '{rd: 0, addr: 12'h000, sv: 0, data: 32'h0,   dn: 0, bz: 0};

        reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; src_ready = 1'b1;
        clear_logs();
        @(negedge clk);
        cycle();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_valid", 32'(src_valid), 32'd0);
        check("byteenable", 32'(avm_byteenable), 32'hF);
        reset = 1'b0;
        cycle();

        // Basic read timing: pipelined issue, 3-cycle start-to-data, done as busy falls.
        clear_logs();
        pulse_start(12'h010, 4);
        for (int j = 0; j < 8; j++) begin
            check($sformatf("basic_rd%0d", j), 32'(avm_read), 32'(steps[j].rd));
            if (steps[j].rd) check($sformatf("basic_addr%0d", j), 32'(avm_address), 32'(steps[j].addr));
            check($sformatf("basic_sv%0d", j), 32'(src_valid), 32'(steps[j].sv));
            if (steps[j].sv) check($sformatf("basic_data%0d", j), src_data, steps[j].data);
            check($sformatf("basic_done%0d", j), 32'(done), 32'(steps[j].dn));
            check($sformatf("basic_busy%0d", j), 32'(busy), 32'(steps[j].bz));
            cycle();
        end
        for (int i = 0; i < 3; i++) cycle();
        verify_seq("basic", 12'h010, 4);

        // Table of directed transfers.
        foreach (vecs[v]) begin
            clear_logs();
            lat_min = 1; lat_max = vecs[v].lmax; ready_rand = vecs[v].rnd; ready_on = 1;
            pulse_start(vecs[v].base, vecs[v].cnt);
            wait_done(2000);
            verify_seq($sformatf("vec%0d", v), vecs[v].base, vecs[v].cnt);
            check($sformatf("vec%0d_first", v), out_log.size() > 0 ? out_log[0] : 32'hFFFF_FFFF,
                  vecs[v].exp_first);
            check($sformatf("vec%0d_last", v),
                  out_log.size() > 0 ? out_log[out_log.size()-1] : 32'hFFFF_FFFF, vecs[v].exp_last);
            check($sformatf("vec%0d_credit", v), 32'(max_out <= FIFO_DEPTH), 32'd1);
        end
        lat_min = 1; lat_max = 1; ready_rand = 0; ready_on = 1;

        // Zero-length request: done next cycle, no reads.
        clear_logs();
        pulse_start(12'h100, 0);
        check("zero_done", 32'(done), 32'd1);
        check("zero_busy", 32'(busy), 32'd0);
        check("zero_read", 32'(avm_read), 32'd0);
        cycle();
        check("zero_done_pulse", 32'(done), 32'd0);
        for (int i = 0; i < 4; i++) cycle();
        check("zero_no_reads", 32'(read_seen), 32'd0);
        check("zero_done_once", 32'(done_cnt), 32'd1);

        // Back-pressure: credit stops issue at FIFO_DEPTH.
        clear_logs();
        ready_on = 0;
        pulse_start(12'h020, 20);
        for (int i = 0; i < 30; i++) cycle();
        check("bp_accepted", 32'(acc_cnt), 32'(FIFO_DEPTH));
        check("bp_read_low", 32'(avm_read), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_valid", 32'(src_valid), 32'd1);
        check("bp_head_hold", src_data, 32'h020);
        ready_on = 1;
        wait_done(500);
        verify_seq("bp", 12'h020, 20);

        // Waitrequest for 3 cycles on the second read.
        clear_logs();
        stall_addr = 12'h011; stall_len = 3; stall_armed = 1;
        pulse_start(12'h010, 6);
        wait_done(200);
        check("stall_hit", 32'(stall_armed), 32'd0);
        verify_seq("stall", 12'h010, 6);

        // Start while busy is ignored.
        clear_logs();
        pulse_start(12'h050, 10);
        for (int i = 0; i < 3; i++) cycle();
        pulse_start(12'h700, 2);
        wait_done(300);
        verify_seq("busy_start", 12'h050, 10);

        // Reset mid-transfer with responses still in flight.
        clear_logs();
        lat_min = 3; lat_max = 3;
        pulse_start(12'h300, 10);
        for (int i = 0; i < 100 && out_log.size() < 5; i++) cycle();
        check("rst_mid_progress", 32'(out_log.size() >= 5), 32'd1);
        n_at_reset    = out_log.size();
        done_at_reset = done_cnt;
        reset = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_read", 32'(avm_read), 32'd0);
        check("rst_mid_addr", 32'(avm_address), 32'd0);
        check("rst_mid_valid", 32'(src_valid), 32'd0);
        check("rst_mid_done", 32'(done), 32'd0);
        cycle();
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        check("rst_late_ignored", 32'(out_log.size()), 32'(n_at_reset));
        check("rst_no_done", 32'(done_cnt), 32'(done_at_reset));
        check("rst_idle_valid", 32'(src_valid), 32'd0);
        clear_logs();
        lat_min = 1; lat_max = 1;
        pulse_start(12'h040, 3);
        wait_done(200);
        verify_seq("after_rst", 12'h040, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
